// File: rtl/regfile_scoreboard.sv
// Register file with two async read ports (optional writeback bypass), one
// writeback port and a per-register busy scoreboard for decode/writeback.
// One address is a read-only I/O register that returns the startIO bit.
module regfile_scoreboard #(
    parameter int WIDTH        = 16,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int IOREG        = 15,
    parameter int BYPASS       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    startIO,
    input  logic [ADDRESSWIDTH-1:0] ra1,
    input  logic [ADDRESSWIDTH-1:0] ra2,
    output logic [WIDTH-1:0]        rd1,
    output logic [WIDTH-1:0]        rd2,
    output logic                    rbusy1,
    output logic                    rbusy2,
    input  logic                    issue_en,
    input  logic [ADDRESSWIDTH-1:0] issue_addr,
    output logic                    issue_ok,
    input  logic                    we3,
    input  logic [ADDRESSWIDTH-1:0] wa3,
    input  logic [WIDTH-1:0]        wd3,
    output logic [ADDRESSWIDTH:0]   busy_cnt,
    output logic                    err_wb
);

    localparam int NADDR = 2 ** ADDRESSWIDTH;
    localparam logic [ADDRESSWIDTH-1:0] IO_ADDR = ADDRESSWIDTH'(IOREG);

    // One bit per address: set for addresses that hold real, writable storage.
    // Built at elaboration so range checks become a simple table lookup.
    function automatic logic [NADDR-1:0] make_valid_mask();
        logic [NADDR-1:0] m;
        m = '0;
        for (int i = 0; i < NADDR; i++) begin
            m[i] = (i < REGNUM) && (i != IOREG);
        end
        return m;
    endfunction

    localparam logic [NADDR-1:0] VALID_MASK = make_valid_mask();

    // Storage spans the full address space; entries outside VALID_MASK are
    // never written and stay at their reset value.
    logic [WIDTH-1:0]        rf [NADDR];
    logic [NADDR-1:0]        busy;
    logic [NADDR-1:0]        busy_next;
    logic [ADDRESSWIDTH:0]   cnt_next;
    logic                    wr_ok;
    logic                    err_set;

    // Shared read-port logic: I/O register, bypass, then storage.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDRESSWIDTH-1:0] ra);
        logic [WIDTH-1:0] d;
        d = '0;
        if (ra == IO_ADDR) begin
            d = {{(WIDTH-1){1'b0}}, startIO};
        end else if (VALID_MASK[ra]) begin
            if ((BYPASS != 0) && we3 && (wa3 == ra)) begin
                d = wd3;
            end else begin
                d = rf[ra];
            end
        end
        return d;
    endfunction

    // Read ports and their busy flags; a retire in flight hides the busy bit.
    always_comb begin
        rd1    = read_port(ra1);
        rd2    = read_port(ra2);
        rbusy1 = VALID_MASK[ra1] && busy[ra1] && !(we3 && (wa3 == ra1));
        rbusy2 = VALID_MASK[ra2] && busy[ra2] && !(we3 && (wa3 == ra2));
    end

    // Issue acceptance, write qualification and next scoreboard state.
    always_comb begin
        wr_ok     = we3 && VALID_MASK[wa3];
        err_set   = wr_ok && !busy[wa3];
        issue_ok  = issue_en && (!VALID_MASK[issue_addr] || !busy[issue_addr] ||
                                 (we3 && (wa3 == issue_addr)));
        busy_next = busy;
        // Retire clears first so a same-register issue in the same cycle leaves it busy.
        if (wr_ok) begin
            busy_next[wa3] = 1'b0;
        end
        if (issue_ok && VALID_MASK[issue_addr]) begin
            busy_next[issue_addr] = 1'b1;
        end
        cnt_next = '0;
        for (int i = 0; i < NADDR; i++) begin
            cnt_next = cnt_next + (ADDRESSWIDTH+1)'(busy_next[i]);
        end
    end

    // Storage, scoreboard, busy count and sticky error update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf       <= '{default: '0};
            busy     <= '0;
            busy_cnt <= '0;
            err_wb   <= 1'b0;
        end else begin
            if (wr_ok) begin
                rf[wa3] <= wd3;
            end
            busy     <= busy_next;
            busy_cnt <= cnt_next;
            if (err_set) begin
                err_wb <= 1'b1;
            end
        end
    end

endmodule
